sys_cntr_rx: RTL and testbench

//   Receive-side system controller: decodes command frames arriving as bytes from the UART receiver
//   (already synchronised into the system clock domain) and drives register-file write/read,
//   ALU enable/function and ALU clock-gate enable. Counterpart of the transmit-side controller that

---
 rtl/sys_cntr_rx_if.sv | 27 ++
 rtl/sys_cntr_rx.sv | 115 +++++++++++
 tb/tb_sys_cntr_rx.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cntr_rx_if.sv
// Byte-in / register-file + ALU control bundle of the receive-side system controller.
// master is the controller side, slave is the UART/register-file/ALU environment side.
interface sys_cntr_rx_if #(
  parameter int unsigned width      = 8,
  parameter int unsigned addr_width = 4
);
  logic [width-1:0]      Rx_Data;
  logic                  Rx_Data_valid;
  logic                  ALU_out_valid;
  logic [addr_width-1:0] Address;
  logic                  WrEn;
  logic [width-1:0]      WrData;
  logic                  RdEn;
  logic                  ALU_EN;
  logic [3:0]            ALU_FUN;
  logic                  CLK_GATE_EN;

  modport master (
    input  Rx_Data, Rx_Data_valid, ALU_out_valid,
    output Address, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN
  );

  modport slave (
    output Rx_Data, Rx_Data_valid, ALU_out_valid,
    input  Address, WrEn, WrData, RdEn, ALU_EN, ALU_FUN, CLK_GATE_EN
  );
endinterface

// File: rtl/sys_cntr_rx.sv
// Receive-side system controller: decodes AA/BB/CC/DD command frames into register-file
// write/read strobes, ALU enable/function and the ALU clock-gate enable. All outputs registered.
module sys_cntr_rx #(
  parameter int unsigned width      = 8,
  parameter int unsigned addr_width = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  sys_cntr_rx_if.master     bus
);

  localparam logic [width-1:0] CmdWr    = width'(8'hAA);
  localparam logic [width-1:0] CmdRd    = width'(8'hBB);
  localparam logic [width-1:0] CmdAluOp = width'(8'hCC);
  localparam logic [width-1:0] CmdAlu   = width'(8'hDD);

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StAluFn, StAluWait
  } state_e;

  state_e                state_q;
  logic [addr_width-1:0] addr_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      bus.Address     <= '0;
      bus.WrEn        <= 1'b0;
      bus.WrData      <= '0;
      bus.RdEn        <= 1'b0;
      bus.ALU_EN      <= 1'b0;
      bus.ALU_FUN     <= '0;
      bus.CLK_GATE_EN <= 1'b0;
    end else begin
      bus.WrEn   <= 1'b0;
      bus.RdEn   <= 1'b0;
      bus.ALU_EN <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.Rx_Data_valid) begin
            unique case (bus.Rx_Data)
              CmdWr: state_q <= StWrAddr;
              CmdRd: state_q <= StRdAddr;
              CmdAluOp: begin
                state_q         <= StOpA;
                bus.CLK_GATE_EN <= 1'b1;
              end
              CmdAlu: begin
                state_q         <= StAluFn;
                bus.CLK_GATE_EN <= 1'b1;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        // Address is staged so the visible Address only moves together with WrEn.
        StWrAddr: begin
          if (bus.Rx_Data_valid) begin
            addr_q  <= bus.Rx_Data[addr_width-1:0];
            state_q <= StWrData;
          end
        end
        StWrData: begin
          if (bus.Rx_Data_valid) begin
            bus.Address <= addr_q;
            bus.WrData  <= bus.Rx_Data;
            bus.WrEn    <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StRdAddr: begin
          if (bus.Rx_Data_valid) begin
            bus.Address <= bus.Rx_Data[addr_width-1:0];
            bus.RdEn    <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StOpA: begin
          if (bus.Rx_Data_valid) begin
            bus.Address <= addr_width'(0);
            bus.WrData  <= bus.Rx_Data;
            bus.WrEn    <= 1'b1;
            state_q     <= StOpB;
          end
        end
        StOpB: begin
          if (bus.Rx_Data_valid) begin
            bus.Address <= addr_width'(1);
            bus.WrData  <= bus.Rx_Data;
            bus.WrEn    <= 1'b1;
            state_q     <= StAluFn;
          end
        end
        StAluFn: begin
          if (bus.Rx_Data_valid) begin
            bus.ALU_FUN <= bus.Rx_Data[3:0];
            bus.ALU_EN  <= 1'b1;
            state_q     <= StAluWait;
          end
        end
        // Incoming bytes are dropped until the ALU reports its result.
        StAluWait: begin
          if (bus.ALU_out_valid) begin
            bus.CLK_GATE_EN <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cntr_rx.sv
// Self-checking bench for sys_cntr_rx: expected strobes are queued as frames are sent and
// checked by a negedge monitor as the DUT raises WrEn/RdEn/ALU_EN.
module tb_sys_cntr_rx;

  logic CLK;
  logic Reset;

  sys_cntr_rx_if #(.width(8), .addr_width(4)) bus ();

  sys_cntr_rx #(.width(8), .addr_width(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [1:0] KWr  = 2'd1;
  localparam logic [1:0] KRd  = 2'd2;
  localparam logic [1:0] KAlu = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Every strobe cycle must match the oldest queued expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (Reset === 1'b1) begin
      if (bus.WrEn === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got WrEn addr=%h data=%h, required no strobe",
                   bus.Address, bus.WrData);
        end else begin
          e = sb.pop_front();
          if (e.kind !== KWr || bus.Address !== e.addr || bus.WrData !== e.data) begin
            n_err++;
            $display("FAIL wr_strobe: got WrEn addr=%h data=%h, required kind=%0d addr=%h data=%h",
                     bus.Address, bus.WrData, e.kind, e.addr, e.data);
          end
        end
      end
      if (bus.RdEn === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got RdEn addr=%h, required no strobe", bus.Address);
        end else begin
          e = sb.pop_front();
          if (e.kind !== KRd || bus.Address !== e.addr) begin
            n_err++;
            $display("FAIL rd_strobe: got RdEn addr=%h, required kind=%0d addr=%h",
                     bus.Address, e.kind, e.addr);
          end
        end
      end
      if (bus.ALU_EN === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL alu_unexpected: got ALU_EN fun=%h, required no strobe", bus.ALU_FUN);
        end else begin
          e = sb.pop_front();
          if (e.kind !== KAlu || bus.ALU_FUN !== e.fun || bus.CLK_GATE_EN !== 1'b1) begin
            n_err++;
            $display("FAIL alu_strobe: got ALU_EN fun=%h gate=%b, required kind=%0d fun=%h gate=1",
                     bus.ALU_FUN, bus.CLK_GATE_EN, e.kind, e.fun);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.Rx_Data       = b;
    bus.Rx_Data_valid = 1'b1;
    @(negedge CLK);
    bus.Rx_Data_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d,
                      input logic [3:0] f);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.fun = f;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d strobes still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Rx_Data = '0; bus.Rx_Data_valid = 1'b0; bus.ALU_out_valid = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({bus.Address, bus.WrEn, bus.WrData, bus.RdEn, bus.ALU_EN, bus.ALU_FUN,
         bus.CLK_GATE_EN} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%h wr=%b wd=%h rd=%b en=%b fun=%h gate=%b, required 0",
               bus.Address, bus.WrEn, bus.WrData, bus.RdEn, bus.ALU_EN, bus.ALU_FUN,
               bus.CLK_GATE_EN);
    end
    Reset = 1'b1;
  endtask

  task automatic test_write();
    send_byte(8'hAA);
    send_byte(8'h05);
    push(KWr, 4'h5, 8'h3C, 4'h0);
    send_byte(8'h3C);
    drain("write");
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (bus.Address !== 4'h5 || bus.WrData !== 8'h3C) begin
      n_err++;
      $display("FAIL write_hold: got addr=%h data=%h, required addr=5 data=3c",
               bus.Address, bus.WrData);
    end
  endtask

  task automatic test_read();
    send_byte(8'hBB);
    push(KRd, 4'hA, 8'h00, 4'h0);
    send_byte(8'h0A);
    drain("read");
    n_cmp++;
    if (bus.Address !== 4'hA || bus.WrData !== 8'h3C) begin
      n_err++;
      $display("FAIL read_hold: got addr=%h data=%h, required addr=a data=3c",
               bus.Address, bus.WrData);
    end
  endtask

  task automatic test_alu_ops();
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b0) begin
      n_err++;
      $display("FAIL gate_idle: got %b, required 0", bus.CLK_GATE_EN);
    end
    send_byte(8'hCC);
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b1) begin
      n_err++;
      $display("FAIL gate_after_cc: got %b, required 1", bus.CLK_GATE_EN);
    end
    push(KWr, 4'h0, 8'h12, 4'h0);
    send_byte(8'h12);
    push(KWr, 4'h1, 8'h34, 4'h0);
    send_byte(8'h34);
    push(KAlu, 4'h0, 8'h00, 4'h0);
    send_byte(8'h00);
    n_cmp++;
    if (bus.ALU_EN !== 1'b1) begin
      n_err++;
      $display("FAIL alu_en_timing: got %b, required 1", bus.ALU_EN);
    end
    repeat (2) @(negedge CLK);
    bus.ALU_out_valid = 1'b1;
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b1) begin
      n_err++;
      $display("FAIL gate_before_done: got %b, required 1", bus.CLK_GATE_EN);
    end
    @(negedge CLK);
    bus.ALU_out_valid = 1'b0;
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b0) begin
      n_err++;
      $display("FAIL gate_after_done: got %b, required 0", bus.CLK_GATE_EN);
    end
    drain("alu_ops");
  endtask

  task automatic test_alu_noops();
    send_byte(8'hDD);
    push(KAlu, 4'h0, 8'h00, 4'h7);
    send_byte(8'h07);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h99);
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b1 || bus.ALU_FUN !== 4'h7) begin
      n_err++;
      $display("FAIL alu_wait: got gate=%b fun=%h, required gate=1 fun=7",
               bus.CLK_GATE_EN, bus.ALU_FUN);
    end
    @(negedge CLK);
    bus.ALU_out_valid = 1'b1;
    @(negedge CLK);
    bus.ALU_out_valid = 1'b0;
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b0 || bus.Address !== 4'h1 || bus.WrData !== 8'h34) begin
      n_err++;
      $display("FAIL alu_noops_end: got gate=%b addr=%h data=%h, required gate=0 addr=1 data=34",
               bus.CLK_GATE_EN, bus.Address, bus.WrData);
    end
    drain("alu_noops");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'hFF; bytes[3] = 8'hCC;
    push(KWr, 4'hF, 8'hCC, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.Rx_Data       = bytes[i];
      bus.Rx_Data_valid = 1'b1;
    end
    @(negedge CLK);
    bus.Rx_Data_valid = 1'b0;
    n_cmp++;
    if (bus.CLK_GATE_EN !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gate: got %b, required 0", bus.CLK_GATE_EN);
    end
    drain("b2b");
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hAA);
    send_byte(8'h03);
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Address, bus.WrEn, bus.WrData, bus.RdEn, bus.ALU_EN, bus.ALU_FUN,
         bus.CLK_GATE_EN} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset: got addr=%h wd=%h wr=%b rd=%b, required all 0",
               bus.Address, bus.WrData, bus.WrEn, bus.RdEn);
    end
    repeat (2) @(negedge CLK);
    Reset = 1'b1;
    send_byte(8'hBB);
    push(KRd, 4'h3, 8'h00, 4'h0);
    send_byte(8'h03);
    drain("midframe");
    n_cmp++;
    if (bus.Address !== 4'h3 || bus.WrData !== 8'h00) begin
      n_err++;
      $display("FAIL midframe_after: got addr=%h data=%h, required addr=3 data=00",
               bus.Address, bus.WrData);
    end
  endtask

  initial begin
    Reset = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_alu_noops();
    test_back_to_back();
    test_reset_midframe();
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
